// File: rtl/sent_pkg.sv
// SENT TX frame scheduler shared definitions.
// Optional build macro: SENT_PAUSE_EN adds the PAUSE state.
package sent_pkg;

    localparam logic [2:0] SYM_SYNC   = 3'd0;
    localparam logic [2:0] SYM_STATUS = 3'd1;
    localparam logic [2:0] SYM_DATA   = 3'd2;
    localparam logic [2:0] SYM_CRC    = 3'd3;
    localparam logic [2:0] SYM_PAUSE  = 3'd4;

    localparam int CMD_TX_EN = 0;
    localparam int CMD_MODE  = 1;
    localparam int CMD_ST_LO = 4;
    localparam int CMD_ST_HI = 5;

    // Entry i lives at bits [4*i+3 : 4*i].
    localparam logic [63:0] CRC4_TABLE = {
        4'd5,  4'd8,  4'd2,  4'd15,
        4'd11, 4'd6,  4'd12, 4'd1,
        4'd4,  4'd9,  4'd3,  4'd14,
        4'd10, 4'd7,  4'd13, 4'd0
    };

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_POP1   = 4'd1,
        ST_LAT1   = 4'd2,
        ST_POP2   = 4'd3,
        ST_LAT2   = 4'd4,
        ST_SYNC   = 4'd5,
        ST_STATUS = 4'd6,
        ST_DATA   = 4'd7,
`ifdef SENT_PAUSE_EN
        ST_CRC    = 4'd8,
        ST_PAUSE  = 4'd9
`else
        ST_CRC    = 4'd8
`endif
    } state_t;

    function automatic logic [3:0] crc4_lookup(input logic [3:0] c);
        return CRC4_TABLE[{c, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/sent_crc4.sv
// One CRC4 step of the SENT fast channel checksum.
// c_out = n XOR T[c_in].
module sent_crc4
    import sent_pkg::*;
(
    input  logic [3:0] c_in,
    input  logic [3:0] n,
    output logic [3:0] c_out
);

    assign c_out = n ^ crc4_lookup(c_in);

endmodule

// File: rtl/sent_tx_frame_scheduler.sv
// SENT TX frame scheduler: FIFO words -> SYNC/STATUS/D1..D6/CRC stream.
// Optional build macro: SENT_PAUSE_EN appends a PAUSE symbol per frame.
module sent_tx_frame_scheduler
    import sent_pkg::*;
#(
    parameter int         DATAWIDTH = 12,
    parameter logic [3:0] CRC_SEED  = 4'h5
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [7:0]           reg_command,
    input  logic                 fifo_empty,
    input  logic [DATAWIDTH-1:0] fifo_rdata,
    output logic                 fifo_rd_en,
    output logic [2:0]           sym_type,
    output logic [3:0]           sym_val,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic [3:0]           crc_out
);

    state_t                 r_state;
    state_t                 w_nxt;
    logic [DATAWIDTH-1:0]   r_w1;
    logic [DATAWIDTH-1:0]   r_w2;
    logic                   r_mode;
    logic [1:0]             r_status;
    logic [2:0]             r_cnt;
    logic [3:0]             r_crc;
    logic [3:0]             r_crc_out;
    logic [3:0]             w_nib;
    logic [3:0]             w_crc_n;
    logic [3:0]             w_crc_c;
    logic                   w_tx_en;
    logic                   w_next_pop;
    logic                   w_unused_cmd;

    assign w_tx_en      = reg_command[CMD_TX_EN];
    assign w_next_pop   = w_tx_en & ~fifo_empty;
    assign w_unused_cmd = ^{reg_command[7:6], reg_command[3:2]};
    assign busy         = (r_state != ST_IDLE);
    assign crc_out      = r_crc_out;
    assign w_crc_n      = (r_state == ST_DATA) ? w_nib : 4'h0;

    sent_crc4 u_crc (
        .c_in  (r_crc),
        .n     (w_crc_n),
        .c_out (w_crc_c)
    );

    // Select the current data nibble, most significant nibble of w1 first.
    always_comb begin
        w_nib = 4'h0;
        case (r_cnt)
            3'd0:    w_nib = r_w1[DATAWIDTH-1 -: 4];
            3'd1:    w_nib = r_w1[DATAWIDTH-5 -: 4];
            3'd2:    w_nib = r_w1[DATAWIDTH-9 -: 4];
            3'd3:    w_nib = r_w2[DATAWIDTH-1 -: 4];
            3'd4:    w_nib = r_w2[DATAWIDTH-5 -: 4];
            3'd5:    w_nib = r_w2[DATAWIDTH-9 -: 4];
            default: w_nib = 4'h0;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= ST_IDLE;
        else          r_state <= w_nxt;
    end

    // Next-state decode and symbol/strobe outputs.
    always_comb begin
        w_nxt      = r_state;
        fifo_rd_en = 1'b0;
        sym_valid  = 1'b0;
        sym_type   = SYM_SYNC;
        sym_val    = 4'h0;
        frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_next_pop) w_nxt = ST_POP1;
            end
            ST_POP1: begin
                fifo_rd_en = 1'b1;
                w_nxt      = ST_LAT1;
            end
            ST_LAT1: begin
                w_nxt = r_mode ? ST_SYNC : ST_POP2;
            end
            ST_POP2: begin
                if (!w_tx_en) begin
                    w_nxt = ST_IDLE;
                end else if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    w_nxt      = ST_LAT2;
                end
            end
            ST_LAT2: begin
                w_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                sym_valid = 1'b1;
                sym_type  = SYM_SYNC;
                if (sym_ready) w_nxt = ST_STATUS;
            end
            ST_STATUS: begin
                sym_valid = 1'b1;
                sym_type  = SYM_STATUS;
                sym_val   = {2'b00, r_status};
                if (sym_ready) w_nxt = ST_DATA;
            end
            ST_DATA: begin
                sym_valid = 1'b1;
                sym_type  = SYM_DATA;
                sym_val   = w_nib;
                if (sym_ready && r_cnt == 3'd5) w_nxt = ST_CRC;
            end
            ST_CRC: begin
                sym_valid = 1'b1;
                sym_type  = SYM_CRC;
                sym_val   = w_crc_c;
`ifdef SENT_PAUSE_EN
                if (sym_ready) w_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                sym_valid = 1'b1;
                sym_type  = SYM_PAUSE;
`endif
                if (sym_ready) begin
                    frame_done = 1'b1;
                    w_nxt      = w_next_pop ? ST_POP1 : ST_IDLE;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Frame context: words, held command fields, nibble counter and CRC.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_w1      <= '0;
            r_w2      <= '0;
            r_mode    <= 1'b0;
            r_status  <= 2'b00;
            r_cnt     <= 3'd0;
            r_crc     <= 4'h0;
            r_crc_out <= 4'h0;
        end else begin
            case (r_state)
                ST_POP1: begin
                    r_mode   <= reg_command[CMD_MODE];
                    r_status <= reg_command[CMD_ST_HI:CMD_ST_LO];
                    r_cnt    <= 3'd0;
                    r_crc    <= CRC_SEED;
                end
                ST_LAT1: begin
                    r_w1 <= fifo_rdata;
                    if (r_mode) r_w2 <= '0;
                end
                ST_LAT2: begin
                    r_w2 <= fifo_rdata;
                end
                ST_DATA: begin
                    if (sym_ready) begin
                        r_crc <= w_crc_c;
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_CRC: begin
                    if (sym_ready) r_crc_out <= w_crc_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_scheduler.sv
// Scoreboard bench for sent_tx_frame_scheduler.
// Honours SENT_PAUSE_EN when the design is built with it.
module tb_sent_tx_frame_scheduler;

    localparam logic [2:0] T_SYNC   = 3'd0;
    localparam logic [2:0] T_STATUS = 3'd1;
    localparam logic [2:0] T_DATA   = 3'd2;
    localparam logic [2:0] T_CRC    = 3'd3;
    localparam logic [2:0] T_PAUSE  = 3'd4;

    localparam logic [3:0] TBL [16] = '{
        4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
        4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5
    };

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [7:0]  reg_command = 8'h00;
    logic        fifo_empty = 1'b1;
    logic [11:0] fifo_rdata = 12'h000;
    logic        fifo_rd_en;
    logic [2:0]  sym_type;
    logic [3:0]  sym_val;
    logic        sym_valid;
    logic        sym_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [3:0]  crc_out;

    int checks = 0;
    int errors = 0;
    int n_pop = 0;
    int n_done = 0;
    int n_valid = 0;

    logic [11:0] fq[$];
    logic [6:0]  exp_q[$];
    logic [3:0]  crc_q[$];

    bit         rdy_rand = 1'b0;
    bit         rdy_val = 1'b1;
    bit         pend_crc = 1'b0;
    bit         held = 1'b0;
    logic [6:0] held_sym = '0;

    sent_tx_frame_scheduler dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .reg_command (reg_command),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd_en  (fifo_rd_en),
        .sym_type    (sym_type),
        .sym_val     (sym_val),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .crc_out     (crc_out)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] crc_model(input logic [11:0] a,
                                             input logic [11:0] b);
        logic [23:0] d;
        logic [3:0]  c;
        d = {a, b};
        c = 4'h5;
        for (int i = 0; i < 6; i++) c = d[23-4*i -: 4] ^ TBL[c];
        return TBL[c];
    endfunction

    // FIFO model: read data appears the cycle after the pop strobe.
    always @(posedge PCLK) begin
        if (PRESETn && fifo_rd_en) begin
            if (fq.size() > 0) fifo_rdata <= fq.pop_front();
            else chk("pop_empty", {31'd0, fifo_empty}, 32'd0);
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic push_word(input logic [11:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic queue_frame(input bit mode, input logic [1:0] st,
                               input logic [11:0] w1, input logic [11:0] w2);
        logic [11:0] b;
        logic [23:0] d;
        b = mode ? 12'h000 : w2;
        d = {w1, b};
        exp_q.push_back({T_SYNC, 4'h0});
        exp_q.push_back({T_STATUS, 2'b00, st});
        for (int i = 0; i < 6; i++) exp_q.push_back({T_DATA, d[23-4*i -: 4]});
        exp_q.push_back({T_CRC, crc_model(w1, b)});
`ifdef SENT_PAUSE_EN
        exp_q.push_back({T_PAUSE, 4'h0});
`endif
        crc_q.push_back(crc_model(w1, b));
        push_word(w1);
        if (!mode) push_word(w2);
    endtask

    task automatic sample();
        if (pend_crc) begin
            pend_crc = 1'b0;
            if (crc_q.size() > 0) chk("crc_out", crc_out, crc_q.pop_front());
        end
        if (held)
            chk("stall_hold", {sym_valid, sym_type, sym_val}, {1'b1, held_sym});
        held     = sym_valid && !sym_ready;
        held_sym = {sym_type, sym_val};
        if (fifo_rd_en) n_pop++;
        if (sym_valid) n_valid++;
        if (sym_valid && sym_ready) begin
            if (exp_q.size() == 0) chk("unexp_sym", {sym_type, sym_val}, 7'h7f);
            else chk("sym", {sym_type, sym_val}, exp_q.pop_front());
        end
        if (frame_done) begin
            n_done++;
            pend_crc = 1'b1;
            chk("done_xfer", {31'd0, sym_valid && sym_ready}, 32'd1);
        end
    endtask

    // Ready driver and output monitor, both a little after the falling edge.
    initial begin
        forever begin
            @(negedge PCLK);
            sym_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
            #1;
            if (PRESETn) sample();
            else begin
                held     = 1'b0;
                pend_crc = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge PCLK);
            #2;
            if (exp_q.size() == 0 && !pend_crc && !busy) break;
        end
        chk(tag, {31'd0, i < budget}, 32'd1);
    endtask

    int p0, d0, v0, k;

    initial begin
        repeat (2) @(negedge PCLK);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, sym_valid}, 32'd0);
        chk("rst_rd", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_crc", {28'd0, crc_out}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        reg_command = 8'h01;
        p0 = n_pop; d0 = n_done;
        queue_frame(1'b0, 2'd0, 12'h000, 12'h000);
        wait_idle("t1_timeout", 200);
        chk("t1_pops", n_pop - p0, 2);
        chk("t1_done", n_done - d0, 1);
        chk("t1_crc", {28'd0, crc_out}, 32'h5);

        reg_command = 8'h21;
        queue_frame(1'b0, 2'd2, 12'hABC, 12'h123);
        wait_idle("t2_timeout", 200);
        chk("t2_crc", {28'd0, crc_out}, {28'd0, crc_model(12'hABC, 12'h123)});

        reg_command = 8'h03;
        p0 = n_pop;
        queue_frame(1'b1, 2'd0, 12'h000, 12'h000);
        wait_idle("t3_timeout", 200);
        chk("t3_pops", n_pop - p0, 1);
        chk("t3_crc", {28'd0, crc_out}, 32'h5);

        rdy_rand = 1'b1;
        d0 = n_done;
        for (int f = 0; f < 6; f++) begin
            logic [1:0]  st;
            logic        md;
            st = 2'($urandom_range(0, 3));
            md = 1'($urandom_range(0, 1));
            reg_command = {2'b00, st, 2'b00, md, 1'b1};
            queue_frame(md, st, 12'($urandom), 12'($urandom));
            wait_idle("t4_timeout", 600);
        end
        chk("t4_done", n_done - d0, 6);
        rdy_rand = 1'b0;

        rdy_val = 1'b0;
        reg_command = 8'h11;
        p0 = n_pop; d0 = n_done;
        queue_frame(1'b0, 2'd1, 12'h9F0, 12'h0E7);
        queue_frame(1'b0, 2'd1, 12'h3C5, 12'hA5A);
        repeat (40) @(negedge PCLK);
        #2;
        chk("stall_pops", n_pop - p0, 2);
        chk("stall_valid", {31'd0, sym_valid}, 32'd1);
        chk("stall_type", {29'd0, sym_type}, {29'd0, T_SYNC});
        rdy_val = 1'b1;
        wait_idle("t5_timeout", 300);
        chk("b2b_pops", n_pop - p0, 4);
        chk("b2b_done", n_done - d0, 2);

        reg_command = 8'h01;
        d0 = n_done;
        queue_frame(1'b0, 2'd0, 12'h5A5, 12'hC3C);
        for (k = 0; k < 50; k++) begin
            @(negedge PCLK);
            #2;
            if (sym_valid) break;
        end
        chk("t6_start", {31'd0, k < 50}, 32'd1);
        reg_command = 8'h00;
        wait_idle("t6_timeout", 200);
        chk("t6_done", n_done - d0, 1);

        reg_command = 8'h01;
        p0 = n_pop; v0 = n_valid;
        push_word(12'h777);
        repeat (6) @(negedge PCLK);
        #2;
        chk("abort_wait", {31'd0, busy}, 32'd1);
        reg_command = 8'h00;
        repeat (3) @(negedge PCLK);
        #2;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_pops", n_pop - p0, 1);
        chk("abort_nosym", n_valid - v0, 0);
        chk("abort_empty", {31'd0, fifo_empty}, 32'd1);

        reg_command = 8'h11;
        queue_frame(1'b0, 2'd1, 12'h246, 12'h8AC);
        for (k = 0; k < 50; k++) begin
            @(negedge PCLK);
            #2;
            if (sym_valid && sym_type == T_DATA) break;
        end
        chk("t8_data", {31'd0, k < 50}, 32'd1);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("rmid_valid", {31'd0, sym_valid}, 32'd0);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_crc", {28'd0, crc_out}, 32'd0);
        exp_q.delete();
        crc_q.delete();
        fq.delete();
        fifo_empty = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        d0 = n_done;
        queue_frame(1'b0, 2'd1, 12'hFED, 12'h987);
        wait_idle("t9_timeout", 200);
        chk("t9_done", n_done - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sent_tx_frame_scheduler.md
Name: sent_tx_frame_scheduler

Overview:
Sequences SENT (SAE J2716) transmit frames between the APB-fed TX FIFO and the downstream nibble pulse encoder.
- Pops 12-bit words from the TX FIFO and assembles one fast-channel frame.
- Computes the CRC4.
- Emits the symbol stream SYNC, STATUS, D1..D6, CRC over a valid/ready handshake.
- Sits between the APB register slave (reg_command, TX FIFO) and the tick-level pulse generator.

Parameters:
- DATAWIDTH, 12, width of a FIFO word and of one fast-channel value.
- CRC_SEED, 4'h5, CRC4 initial value.

Ports:
- PCLK  input  1  system clock
- PRESETn  input  1  asynchronous active-low reset
- reg_command  input  8  bit0 tx_en; bit1 mode (0 = two words per frame, 1 = one word per frame); bits[5:4] status nibble bits[1:0]
- fifo_empty  input  1  TX FIFO empty
- fifo_rdata  input  DATAWIDTH  TX FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_en  output  1  single-cycle pop strobe
- sym_type  output  3  0 SYNC, 1 STATUS, 2 DATA, 3 CRC, 4 PAUSE
- sym_val  output  4  nibble value (0 for SYNC/PAUSE)
- sym_valid  output  1  symbol offered
- sym_ready  input  1  encoder accepts symbol
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse when the last symbol of a frame transfers
- crc_out  output  4  CRC of the last completed frame

Behaviour:
Interface:
- Clock PCLK, rising edge.
- Reset PRESETn, asynchronous, active-low.
- All outputs reset to 0; state resets to IDLE.

States: IDLE, POP1, LAT1, POP2, LAT2, SYNC, STATUS, DATA, CRC, PAUSE (only with the macro).
- IDLE -> POP1 when tx_en=1 and fifo_empty=0. fifo_rd_en is high for exactly the POP1 cycle.
- LAT1: capture fifo_rdata into w1.
  - mode=1: w2 := 0, go to SYNC.
  - mode=0: go to POP2.
- POP2: wait while fifo_empty=1. When non-empty, pulse fifo_rd_en and go to LAT2.
- LAT2: capture w2, go to SYNC.
- Abort: tx_en=0 while in POP2 -> IDLE; w1 is discarded; no frame is emitted.
- mode and status bits are sampled in POP1 and held for the whole frame.

Handshake:
- type/val are stable while sym_valid=1 and sym_ready=0.
- Transfer occurs on a cycle where sym_valid and sym_ready are both 1.
- The next symbol is offered the following cycle with no bubble; sym_valid stays high from SYNC through the final symbol.

Frame content:
- STATUS val = {2'b00, status[1:0]}.
- DATA: 6-cycle counter. Nibbles are w1[11:8], w1[7:4], w1[3:0], w2[11:8], w2[7:4], w2[3:0] (MSN first).
- CRC:
  - c = CRC_SEED.
  - For each data nibble: c = n XOR T[c].
  - After D6 apply one extra step c = T[c].
  - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
  - STATUS is excluded from the CRC.
  - The CRC is updated incrementally on each DATA transfer.
- On the final transfer: frame_done=1 for one cycle and crc_out is updated.
  - If tx_en=1 and the FIFO is non-empty, go directly to POP1; otherwise go to IDLE.

Boundary conditions:
- tx_en cleared during SYNC..CRC: the frame completes; no truncation.
- sym_ready held low indefinitely: the block stalls; no FIFO pops.
- Reset mid-frame: immediate IDLE; sym_valid drops asynchronously.

Optional Feature:
SENT_PAUSE_EN
- Defined: after CRC, emit a PAUSE symbol (type 4, val 0). frame_done pulses on the PAUSE transfer.
- Undefined: the frame ends at CRC, and PAUSE state and encoding logic are absent.

Decomposition:
- Package sent_pkg:
  - sym_type localparams (SYM_SYNC..SYM_PAUSE)
  - state enum encodings
  - CRC4 table constant
  - command bit-index constants
- Sub-module sent_crc4: combinational nibble step (c_in, n -> c_out), instantiated once.

Test Plan:
- mode=0, FIFO={0x000,0x000}, sym_ready=1 -> SYNC, STATUS 0, six DATA 0, CRC 5; two fifo_rd_en pulses; frame_done once; crc_out=5.
- mode=0, FIFO={0xABC,0x123}, status bits=2'b10 -> STATUS 2, DATA A,B,C,1,2,3 in order; CRC matches the reference model.
- mode=1, FIFO={0x000} -> one pop; DATA 0×6; CRC 5.
- sym_ready toggled randomly -> symbols are never dropped or duplicated; type/val stay stable while stalled.
- mode=0, one word in FIFO, then tx_en cleared -> return to IDLE; no SYNC emitted; busy=0.
- With SENT_PAUSE_EN, back-to-back frames with 4 words queued -> PAUSE follows each CRC; second frame's SYNC appears after POP1/LAT1/POP2/LAT2.
